// File: rtl/debounce_multi_pkg.sv
// Common constants shared by the debouncer slice.
package debounce_multi_pkg;

  // Fewer than two flops cannot resolve metastability on a raw board input.
  localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/debounce_multi_chan.sv
// One debouncer channel: synchroniser, stability counter and edge pulses.
module debounce_chan #(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [CNT_W-1:0] width,
  input  logic             d,
  output logic             q,
  output logic             rise,
  output logic             fall
);

  logic [SYNC_STAGES-1:0] syncChain_q;
  logic                   syncOut;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [CNT_W-1:0]       widthMinusOne;
  logic                   countDone;

  // Shift the raw input through the synchroniser; the last stage is the clean sample.
  always_ff @(posedge clk) begin
    if (arst) begin
      syncChain_q <= '0;
    end else begin
      syncChain_q <= {syncChain_q[SYNC_STAGES-2:0], d};
    end
  end

  assign syncOut       = syncChain_q[SYNC_STAGES-1];
  assign widthMinusOne = width - CNT_W'(1);

  // Widths of 0 and 1 both mean "flip on the first differing cycle"; the
  // explicit test also keeps width-1 from wrapping when width is 0.
  assign countDone = (width <= CNT_W'(1)) || (cnt_q >= widthMinusOne);

  // Decide whether the sampled level has been stable long enough to be accepted.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (syncOut != level_q) begin
      if (countDone) begin
        level_d = syncOut;
        rise_d  = syncOut;
        fall_d  = ~syncOut;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Register the level, counter and pulses so the pulses line up with the q change.
  always_ff @(posedge clk) begin
    if (arst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign q    = level_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/debounce_multi.sv
// N independent debouncer channels sharing one run-time stability width.
module debounce_multi
  import debounce_multi_pkg::*;
#(
  parameter int N           = 4,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [CNT_W-1:0] width,
  input  logic [N-1:0]     d,
  output logic [N-1:0]     q,
  output logic [N-1:0]     rise,
  output logic [N-1:0]     fall
);

  // Refuse to build with a synchroniser too short to be safe.
  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : gSyncCheck
    $error("debounce_multi: SYNC_STAGES must be at least %0d", MIN_SYNC_STAGES);
  end

  // One self-contained channel per input bit; only width, clk and arst are shared.
  for (genvar i = 0; i < N; i++) begin : gChan
    debounce_chan #(
      .CNT_W      (CNT_W),
      .SYNC_STAGES(SYNC_STAGES)
    ) uChan (
      .clk  (clk),
      .arst (arst),
      .width(width),
      .d    (d[i]),
      .q    (q[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

endmodule

// File: doc/debounce_multi.md
# debounce_multi

Parametrised multi-channel debouncer that replaces the single-bit `debounce` block. Each of `N` asynchronous inputs (push-buttons, switches, external strobes) passes through its own synchroniser and a stability counter, giving a clean level output and one-cycle rise/fall pulses per channel. The block sits between board I/O and the CPU's memory-mapped input logic, with one shared run-time `width` setting.

## Interface
- `N`, 4: number of independent channels.
- `CNT_W`, 32: width of the stability counter and of the `width` port.
- `SYNC_STAGES`, 2: synchroniser flops per channel; legal values are 2 or more.
- `clk`  input  1  system clock; all logic is on the rising edge.
- `arst`  input  1  reset; synchronous and active-high.
- `width`  input  CNT_W  number of consecutive stable cycles required before `q` changes; shared by all channels.
- `d`  input  N  raw asynchronous inputs.
- `q`  output  N  debounced levels.
- `rise`  output  N  one-cycle pulse in the cycle `q[i]` goes 0→1.
- `fall`  output  N  one-cycle pulse in the cycle `q[i]` goes 1→0.

## Operation
- Per channel `i`, `s[i]` is the last synchroniser stage.
- Each channel has an independent counter `cnt[i]` of `CNT_W` bits.
- At every edge with `arst` low, when `s[i] == q[i]`:
  - `cnt[i] <= 0`.
- At every edge with `arst` low, when `s[i] != q[i]`:
  - If `width <= 1` or `cnt[i] >= width-1`: `q[i] <= s[i]`, `cnt[i] <= 0`, and pulse `rise[i]` or `fall[i]` according to the new value.
  - Otherwise `cnt[i] <= cnt[i]+1`.
- `cnt` cannot overflow, because it clears on every flip and `width` is at most 2^CNT_W−1.
- `width = 0` behaves exactly as `width = 1`: `q` follows `s` with one cycle of delay.
- Any reversion of `s[i]` before the count completes clears `cnt[i]`. A glitch shorter than `width` cycles (after synchronisation) never reaches `q`.
- If `width` changes mid-count, the new value takes effect at the next edge. Because the comparison is `>=`, lowering `width` below the current count flips `q` on that edge.
- `rise`/`fall` are registered and never high for more than one consecutive cycle.
- For any channel, `rise[i]` and `fall[i]` are never high together.
- Channels share nothing except `width`, `clk` and `arst`.

## Timing
- Reset: while `arst` is high at an edge, all synchroniser flops, `cnt`, `q`, `rise` and `fall` go to 0.
- Reset mid-count discards the count.
- An input held at 1 through reset produces `rise` after the full latency following release; this is intended.
- Latency: if `d[i]` changes between edges and then holds, `s[i]` changes at edge `SYNC_STAGES`. `q[i]`, together with its pulse, changes at edge `SYNC_STAGES + max(width,1)`.
  - Example: `SYNC_STAGES=2`, `width=20` gives 22 edges.
- Pulses are aligned with the `q` transition, not delayed a further cycle.

## Structure
- Sub-module `debounce_chan` holds one synchroniser, counter and edge logic, with parameters `CNT_W` and `SYNC_STAGES`. `debounce_multi` instantiates it `N` times in a generate loop.
- No shared package is needed.
- Add a constant for the minimum legal `SYNC_STAGES` (2) to the existing common constants file. `debounce_multi` checks it with an elaboration-time assertion.

## Test plan
Common setup: `N=4`, `CNT_W=32`, `SYNC_STAGES=2`, 10 ns clock, `width=20`, reset high for 2 cycles.
- Glitch rejection: `d[0]` high for 9 ns → `q[0]` stays 0, no pulse; `cnt[0]` returns to 0.
- Clean press/release: `d[0]` high for 300 ns, then low → `rise[0]` high for exactly one cycle, 22 edges after the first edge that samples `d[0]` high. `fall[0]` occurs 22 edges after the first edge that samples it low.
- Channel independence: `d[1]` toggles every 50 ns while `d[2]` holds high → `q[1]` stays 0 and `q[2]` rises after 22 edges; channels 0 and 3 are unaffected.
- `width = 0` and `width = 1`: a step on `d[3]` → `q[3]` follows after exactly 3 edges in both cases.
- Width lowered mid-count: `d[0]` held high, `width` changed 20→5 after 10 counted cycles → `q[0]` rises on the next edge.
- Reset mid-count: `arst` pulsed at count 15 while `d[0]` stays high → `q` and `cnt` are 0. `q[0]` rises 22 edges after reset release, with one `rise[0]` pulse.
